// File: rtl/f3m_addsub_seq.sv
// Digit-serial GF(3^M) adder/subtractor: A+B, A-B, -A, 2A computed DIGITS trits per clock
// under a start/busy/done handshake. Each lane handles one trit per cycle.

module f3m_trit_addsub (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  output logic [1:0] r,
  output logic       ill
);
  logic [1:0] av, bv, x, y;
  logic [2:0] s;

  always_comb begin
    av  = (a == 2'b11) ? 2'b00 : a;
    bv  = (b == 2'b11) ? 2'b00 : b;
    ill = (a == 2'b11) | ((op != 2'b10) & (b == 2'b11));
    x   = (op == 2'b10) ? 2'b00 : av;
    // negation of a trit is a swap of its two bits
    case (op)
      2'b00:   y = bv;
      2'b01:   y = {bv[0], bv[1]};
      2'b10:   y = {av[0], av[1]};
      default: y = av;
    endcase
    s = {1'b0, x} + {1'b0, y};
    r = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  end
endmodule

module f3m_addsub_seq #(
  parameter int M      = 97,
  parameter int DIGITS = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [2*M-1:0] A,
  input  logic [2*M-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] C,
  output logic           err
);
  localparam int NCYC = (M + DIGITS - 1) / DIGITS;
  localparam int PW   = NCYC * DIGITS;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2*PW-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [2*M-1:0]  c_q, c_d;

  logic [DIGITS-1:0][1:0] chunk;
  logic [DIGITS-1:0]      ill;
  logic [2*PW-1:0]        chunk_ext;

  // operands are padded to a whole number of chunks with zero trits, so the
  // padding never raises err and lands above bit 2*M-1 of the work register
  for (genvar j = 0; j < DIGITS; j++) begin : g_lane
    f3m_trit_addsub u_lane (
      .a   (a_q[2*j+1:2*j]),
      .b   (b_q[2*j+1:2*j]),
      .op  (op_q),
      .r   (chunk[j]),
      .ill (ill[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    c_d       = c_q;
    chunk_ext = '0;
    chunk_ext[2*DIGITS-1:0] = chunk;
    case (state_q)
      S_RUN: begin
        a_d    = a_q >> (2*DIGITS);
        b_d    = b_q >> (2*DIGITS);
        work_d = (work_q >> (2*DIGITS)) | (chunk_ext << (2*(PW-DIGITS)));
        err_d  = err_q | (|ill);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(NCYC-1)) begin
          c_d     = work_d[2*M-1:0];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          a_d = '0;
          a_d[2*M-1:0] = A;
          b_d = '0;
          b_d[2*M-1:0] = B;
          op_d    = op;
          work_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      c_q     <= c_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign C    = c_q;
  assign err  = err_q;
endmodule

// File: tb/tb_f3m_addsub_seq.sv
// Bench for f3m_addsub_seq: four instances at DIGITS 1, 8, 96, 97 share operands;
// results are compared against a trit-wise mod-3 reference model.

module tb_f3m_addsub_seq;
  localparam int M = 97;
  typedef logic [2*M-1:0] elem_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] start_v = '0;
  logic [1:0] op = '0;
  elem_t      A = '0, B = '0;
  logic       busy_w [4];
  logic       done_w [4];
  logic       err_w  [4];
  elem_t      c_w    [4];
  int         checks = 0, errors = 0;
  elem_t      last_c;
  logic       last_e;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 96 : 97;
    f3m_addsub_seq #(.M(M), .DIGITS(DG)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start_v[g]), .op(op), .A(A), .B(B),
      .busy(busy_w[g]), .done(done_w[g]), .C(c_w[g]), .err(err_w[g])
    );
  end

  function automatic int digits_of(input int d);
    case (d)
      0: return 1;
      1: return 8;
      2: return 96;
      default: return 97;
    endcase
  endfunction

  function automatic int ncyc_of(input int d);
    return (M + digits_of(d) - 1) / digits_of(d);
  endfunction

  task automatic chk(input string tag, input elem_t got, input elem_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input elem_t a, input elem_t b,
                                output elem_t c, output logic e);
    int ta, tb, av, bv, r;
    c = '0;
    e = 1'b0;
    for (int i = 0; i < M; i++) begin
      ta = int'(a[2*i +: 2]);
      tb = int'(b[2*i +: 2]);
      av = ta;
      bv = tb;
      if (ta == 3) begin e = 1'b1; av = 0; end
      if (tb == 3) begin if (o != 2'd2) e = 1'b1; bv = 0; end
      case (o)
        2'd0:    r = (av + bv) % 3;
        2'd1:    r = (av + 3 - bv) % 3;
        2'd2:    r = (3 - av) % 3;
        default: r = (2 * av) % 3;
      endcase
      c[2*i +: 2] = 2'(r);
    end
  endfunction

  function automatic elem_t rand_elem(input int pct);
    elem_t e;
    int unsigned t;
    e = '0;
    for (int i = 0; i < M; i++) begin
      t = $urandom_range(2);
      if ($urandom_range(99) < pct) t = 3;
      e[2*i +: 2] = 2'(t);
    end
    return e;
  endfunction

  function automatic elem_t fill(input logic [1:0] t);
    elem_t e;
    for (int i = 0; i < M; i++) e[2*i +: 2] = t;
    return e;
  endfunction

  task automatic run_op(input int d, input logic [1:0] o, input elem_t a, input elem_t b,
                        input string tag);
    elem_t ec, prev;
    logic  ee, moved;
    int    n;
    model(o, a, b, ec, ee);
    @(negedge clk);
    op = o; A = a; B = b; start_v[d] = 1'b1;
    prev = c_w[d];
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    op = 2'($urandom); A = rand_elem(50); B = rand_elem(50);
    chk({tag, ".busy_hi"}, elem_t'(busy_w[d]), 1);
    n = 0;
    moved = 1'b0;
    while (done_w[d] !== 1'b1 && n < 2000) begin
      if (c_w[d] !== prev) moved = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, elem_t'(n), elem_t'(ncyc_of(d)));
    chk({tag, ".c_stable_run"}, elem_t'(moved), 0);
    chk({tag, ".C"}, c_w[d], ec);
    chk({tag, ".err"}, elem_t'(err_w[d]), elem_t'(ee));
    chk({tag, ".busy_lo"}, elem_t'(busy_w[d]), 0);
    last_c = c_w[d];
    last_e = err_w[d];
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, elem_t'(done_w[d]), 0);
    chk({tag, ".c_hold"}, c_w[d], last_c);
  endtask

  initial begin
    elem_t a, b, ec;
    logic  ee;
    int    nd, first, lastd, badgap;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d.busy", d), elem_t'(busy_w[d]), 0);
      chk($sformatf("rst%0d.done", d), elem_t'(done_w[d]), 0);
      chk($sformatf("rst%0d.err", d), elem_t'(err_w[d]), 0);
      chk($sformatf("rst%0d.C", d), c_w[d], 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    run_op(1, 2'd0, fill(2'b01), fill(2'b01), "t2");
    chk("t2.all2", last_c, fill(2'b10));
    chk("t2.err0", elem_t'(last_e), 0);

    a = '0; a[1:0] = 2'b10; a[193:192] = 2'b01;
    b = '0; b[1:0] = 2'b01; b[193:192] = 2'b10;
    ec = '0; ec[1:0] = 2'b01; ec[193:192] = 2'b10;
    run_op(1, 2'd1, a, b, "t3");
    chk("t3.const", last_c, ec);

    run_op(1, 2'd2, fill(2'b10), rand_elem(30), "t4");
    chk("t4.all1", last_c, fill(2'b01));
    chk("t4.err0", elem_t'(last_e), 0);

    a = rand_elem(0); a[101:100] = 2'b11;
    run_op(1, 2'd3, a, rand_elem(0), "t5");
    chk("t5.trit50", elem_t'(last_c[101:100]), 0);
    chk("t5.err1", elem_t'(last_e), 1);
    run_op(1, 2'd0, rand_elem(0), rand_elem(0), "t5c");
    chk("t5c.err0", elem_t'(last_e), 0);

    // reset mid-run, after a result with err=1 so every output has something to clear
    run_op(1, 2'd3, a, rand_elem(0), "t1p");
    @(negedge clk);
    A = rand_elem(0); B = rand_elem(0); op = 2'd0; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t1.busy", elem_t'(busy_w[1]), 0);
    chk("t1.done", elem_t'(done_w[1]), 0);
    chk("t1.err", elem_t'(err_w[1]), 0);
    chk("t1.C", c_w[1], 0);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (ncyc_of(1) + 6) begin
      @(posedge clk); #1;
      if (done_w[1] === 1'b1) nd++;
    end
    chk("t1.no_done", elem_t'(nd), 0);

    // start held high: back-to-back ops, done every NCYC+1 cycles
    a = rand_elem(0); b = rand_elem(0);
    model(2'd1, a, b, ec, ee);
    @(negedge clk);
    A = a; B = b; op = 2'd1; start_v[1] = 1'b1;
    @(posedge clk); #1;
    nd = 0; first = -1; lastd = -1; badgap = 0;
    for (int e = 1; e <= 3*(ncyc_of(1)+1) - 1; e++) begin
      @(posedge clk); #1;
      if (done_w[1] === 1'b1) begin
        nd++;
        if (first < 0) first = e;
        if (lastd >= 0 && e - lastd != ncyc_of(1) + 1) badgap++;
        if (busy_w[1] !== 1'b0) badgap++;
        lastd = e;
      end else if (e > 1 && busy_w[1] !== 1'b1 && done_w[1] !== 1'b1) badgap++;
    end
    start_v[1] = 1'b0;
    chk("t6.ndone", elem_t'(nd), 3);
    chk("t6.first", elem_t'(first), elem_t'(ncyc_of(1)));
    chk("t6.gaps", elem_t'(badgap), 0);
    chk("t6.C", c_w[1], ec);
    @(posedge clk); #1;
    chk("t6.idle", elem_t'(busy_w[1]), 0);

    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 10; k++)
        run_op(d, 2'($urandom_range(3)), rand_elem(3), rand_elem(3),
               $sformatf("rnd_d%0d_%0d", digits_of(d), k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
